// File: rtl/score_pkg.sv
// Shared types and constants for the scoreboard score/scan stage.
// Provides the BCD digit type, digit count, saturation value, the reset
// values of the blanking/point vectors, and the hit-points clamp helper.
package score_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SCORE_W = DIGITS * DIGIT_W;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t                 BCD_MAX   = 4'd9;
  localparam logic [SCORE_W-1:0]   SCORE_MAX = 16'h9999;
  localparam logic [DIGITS-1:0]    LES_RST   = 4'b1110;
  localparam logic [DIGITS-1:0]    POINT_RST = 4'b0000;

  // Points above 9 would produce invalid BCD in the ones digit; clamp them.
  function automatic bcd_t clamp_pts(input logic [3:0] pts);
    return (pts > BCD_MAX) ? BCD_MAX : bcd_t'(pts);
  endfunction

endpackage

// File: rtl/score_scan_ctrl_if.sv
// Bus between the game/judge logic, the score/scan stage and the display mux.
// Signals: clr, hit, hit_pts (requests into the stage);
//          Hexs, Scan, Point, Les, sat (display data out of the stage).
// Modports: master = requester/display side, slave = score_scan_ctrl.
interface score_scan_ctrl_if;
  import score_pkg::*;

  logic                 clr;
  logic                 hit;
  logic [3:0]           hit_pts;
  logic [SCORE_W-1:0]   Hexs;
  logic [1:0]           Scan;
  logic [DIGITS-1:0]    Point;
  logic [DIGITS-1:0]    Les;
  logic                 sat;

  modport master (
    output clr, hit, hit_pts,
    input  Hexs, Scan, Point, Les, sat
  );

  modport slave (
    input  clr, hit, hit_pts,
    output Hexs, Scan, Point, Les, sat
  );

endinterface

// File: rtl/score_scan_ctrl_bcd_digit_add.sv
// One stage of the BCD ripple adder.
// Ports: a (BCD digit), b (addend digit 0..9), cin -> sum (BCD digit), cout.
module bcd_digit_add
  import score_pkg::*;
(
  input  bcd_t       a,
  input  logic [3:0] b,
  input  logic       cin,
  output bcd_t       sum,
  output logic       cout
);

  logic [4:0] raw;

  // Binary sum, then decimal correction when the digit exceeds 9.
  always_comb begin
    raw  = 5'(a) + 5'(b) + 5'(cin);
    cout = (raw > 5'(BCD_MAX));
    sum  = cout ? bcd_t'(raw - 5'd10) : bcd_t'(raw);
  end

endmodule

// File: rtl/score_scan_ctrl.sv
// Score accumulator and digit-scan generator feeding the 4-digit display mux.
// Ports: clk, rst (async, active-high), bus (score_scan_ctrl_if.slave):
//   clr/hit/hit_pts in; Hexs (packed BCD score), Scan (digit index),
//   Point (decimal points), Les (per-digit blanking), sat (score at 9999) out.
// Optional macro SCORE_SAT_BLINK_EN: blanks the whole display on alternate
//   blink phases while the score is saturated.
module score_scan_ctrl
  import score_pkg::*;
#(
  parameter int unsigned CNT_W     = 18,
  parameter int unsigned BLINK_BIT = 24
) (
  input  logic               clk,
  input  logic               rst,
  score_scan_ctrl_if.slave   bus
);

  if (BLINK_BIT < CNT_W) begin : g_bad_param
    $error("BLINK_BIT must be >= CNT_W");
  end

`ifdef SCORE_SAT_BLINK_EN
  localparam int unsigned DIV_W = BLINK_BIT + 1;
`else
  localparam int unsigned DIV_W = CNT_W;
`endif

  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d, sum_w;
  logic               sat_q, sat_d;
  logic [DIGITS:0]    carry;
  logic [DIGITS-1:0]  les_c;
  bcd_t               pts;

  // Free-running scan divider; never disturbed by score activity.
  assign cnt_d = cnt_q + DIV_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Ripple chain: the clamped points enter the ones digit, carries do the rest.
  assign pts      = clamp_pts(bus.hit_pts);
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add
    bcd_digit_add u_add (
      .a    (score_q[DIGIT_W*i +: DIGIT_W]),
      .b    ((i == 0) ? pts : 4'd0),
      .cin  (carry[i]),
      .sum  (sum_w[DIGIT_W*i +: DIGIT_W]),
      .cout (carry[i+1])
    );
  end

  // Next score: clear wins over hit; saturated score ignores hits.
  always_comb begin
    score_d = score_q;
    sat_d   = sat_q;
    if (bus.clr) begin
      score_d = '0;
      sat_d   = 1'b0;
    end else if (bus.hit && !sat_q) begin
      if (carry[DIGITS]) begin
        score_d = SCORE_MAX;
        sat_d   = 1'b1;
      end else begin
        score_d = sum_w;
        sat_d   = (sum_w == SCORE_MAX);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      score_q <= score_d;
      sat_q   <= sat_d;
    end
  end

  // Leading-zero blanking; the ones digit always shows.
  always_comb begin
    les_c    = '0;
    les_c[3] = (score_q[15:12] == 4'd0);
    les_c[2] = les_c[3] & (score_q[11:8] == 4'd0);
    les_c[1] = les_c[2] & (score_q[7:4] == 4'd0);
    les_c[0] = 1'b0;
  end

`ifdef SCORE_SAT_BLINK_EN
  logic blink_q;

  // Toggle on each rising edge of the divider-extension bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          blink_q <= 1'b0;
    else if (bus.clr)                                 blink_q <= 1'b0;
    else if (cnt_d[BLINK_BIT] && !cnt_q[BLINK_BIT])   blink_q <= ~blink_q;
  end

  assign bus.Les = (sat_q && blink_q) ? {DIGITS{1'b1}} : les_c;
`else
  assign bus.Les = les_c;
`endif

  assign bus.Hexs  = score_q;
  assign bus.sat   = sat_q;
  assign bus.Scan  = cnt_q[CNT_W-1 -: 2];
  assign bus.Point = POINT_RST;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Self-checking bench for score_scan_ctrl (small divider so scan wraps quickly).
module tb_score_scan_ctrl;
  import score_pkg::*;

  typedef struct packed {
    logic [15:0] hexs;
    logic        sat;
    logic [3:0]  les;
  } exp_t;

  logic clk, rst;
  score_scan_ctrl_if bus();

  score_scan_ctrl #(.CNT_W(4), .BLINK_BIT(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_sc   = 0;
  exp_t sb[$];
  exp_t e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] les_of(input int v);
    if (v >= 1000)    return 4'b0000;
    else if (v >= 100) return 4'b1000;
    else if (v >= 10)  return 4'b1100;
    else               return 4'b1110;
  endfunction

  // Drive one request cycle and push the model's expected outcome.
  task automatic apply(input logic c, input logic h, input int p);
    @(negedge clk);
    bus.clr     = c;
    bus.hit     = h;
    bus.hit_pts = 4'(p);
    if (c) m_sc = 0;
    else if (h) begin
      m_sc += (p > 9) ? 9 : p;
      if (m_sc > 9999) m_sc = 9999;
    end
    sb.push_back('{hexs: to_bcd(m_sc), sat: (m_sc == 9999), les: les_of(m_sc)});
    @(posedge clk);
    #1;
    bus.clr     = 1'b0;
    bus.hit     = 1'b0;
    bus.hit_pts = 4'd0;
  endtask

  // Every digit must be valid BCD and points stay dark.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (bus.Hexs[15:12] > 4'd9 || bus.Hexs[11:8] > 4'd9 ||
          bus.Hexs[7:4] > 4'd9 || bus.Hexs[3:0] > 4'd9 || bus.Point !== 4'b0000) begin
        n_fail++;
        $display("FAIL bcd_valid: Hexs=%h Point=%b, want BCD digits and Point=0000", bus.Hexs, bus.Point);
      end
    end
  end

  task automatic test_reset;
    n_cmp++;
    if ({bus.Hexs, bus.Scan, bus.Les, bus.sat} !== {16'h0000, 2'b00, 4'b1110, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_init: Hexs=%h Scan=%b Les=%b sat=%b, want 0000/00/1110/0",
               bus.Hexs, bus.Scan, bus.Les, bus.sat);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, (i < 4) ? 9 : 6);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.Hexs, bus.sat, bus.Les} !== {e.hexs, e.sat, e.les}) begin
        n_fail++;
        $display("FAIL reset_build: got %h/%b/%b want %h/%b/%b", bus.Hexs, bus.sat, bus.Les, e.hexs, e.sat, e.les);
      end
    end
    // Asynchronous reset mid-cycle with score 0042.
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.Hexs, bus.Scan, bus.Les, bus.sat} !== {16'h0000, 2'b00, 4'b1110, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: Hexs=%h Scan=%b Les=%b sat=%b, want 0000/00/1110/0",
               bus.Hexs, bus.Scan, bus.Les, bus.sat);
    end
    #1 rst = 1'b0;
    m_sc = 0;
  endtask

  task automatic test_back_to_back;
    int pts_l[6] = '{7, 7, 7, 0, 9, 3};
    logic hit_l[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, hit_l[i], pts_l[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.Hexs, bus.sat, bus.Les} !== {e.hexs, e.sat, e.les}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h/%b/%b want %h/%b/%b", i, bus.Hexs, bus.sat, bus.Les, e.hexs, e.sat, e.les);
      end
    end
  endtask

  task automatic test_ripple_carry;
    apply(1'b1, 1'b0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 112; i++) begin
      apply(1'b0, 1'b1, (i < 110) ? 9 : 5);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.Hexs, bus.sat, bus.Les} !== {e.hexs, e.sat, e.les}) begin
        n_fail++;
        $display("FAIL ripple[%0d]: got %h/%b/%b want %h/%b/%b", i, bus.Hexs, bus.sat, bus.Les, e.hexs, e.sat, e.les);
      end
    end
    n_cmp++;
    if ({bus.Hexs, bus.Les} !== {16'h1000, 4'b0000}) begin
      n_fail++;
      $display("FAIL ripple_final: Hexs=%h Les=%b, want 1000/0000", bus.Hexs, bus.Les);
    end
  endtask

  // Les is left to test_sat_display because blinking may darken it.
  task automatic test_saturation;
    apply(1'b1, 1'b0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 1111; i++) begin
      apply(1'b0, 1'b1, 9);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.Hexs, bus.sat} !== {e.hexs, e.sat}) begin
        n_fail++;
        $display("FAIL sat_exact[%0d]: got %h/%b want %h/%b", i, bus.Hexs, bus.sat, e.hexs, e.sat);
      end
    end
    apply(1'b1, 1'b0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 1113; i++) begin
      apply(1'b0, 1'b1, (i < 1110) ? 9 : (i == 1110) ? 5 : (i == 1111) ? 12 : 3);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.Hexs, bus.sat} !== {e.hexs, e.sat}) begin
        n_fail++;
        $display("FAIL sat_clamp[%0d]: got %h/%b want %h/%b", i, bus.Hexs, bus.sat, e.hexs, e.sat);
      end
    end
    n_cmp++;
    if ({bus.Hexs, bus.sat} !== {16'h9999, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_final: Hexs=%h sat=%b, want 9999/1", bus.Hexs, bus.sat);
    end
  endtask

  task automatic test_sat_display;
    int n_dark = 0;
    int n_lit  = 0;
    int n_bad  = 0;
    repeat (400) begin
      @(negedge clk);
      if (bus.Les === 4'b1111)      n_dark++;
      else if (bus.Les === 4'b0000) n_lit++;
      else                          n_bad++;
    end
    n_cmp++;
`ifdef SCORE_SAT_BLINK_EN
    if (n_dark == 0 || n_lit == 0 || n_bad != 0) begin
`else
    if (n_dark != 0 || n_lit != 400 || n_bad != 0) begin
`endif
      n_fail++;
      $display("FAIL sat_display: dark=%0d lit=%0d other=%0d over 400 cycles", n_dark, n_lit, n_bad);
    end
  endtask

  task automatic test_clr_priority;
    for (int i = 0; i < 36; i++) begin
      if (i == 0)       apply(1'b1, 1'b0, 0);
      else if (i < 34)  apply(1'b0, 1'b1, 9);
      else if (i == 34) apply(1'b0, 1'b1, 3);
      else              apply(1'b1, 1'b1, 4);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.Hexs, bus.sat, bus.Les} !== {e.hexs, e.sat, e.les}) begin
        n_fail++;
        $display("FAIL clr_priority[%0d]: got %h/%b/%b want %h/%b/%b", i, bus.Hexs, bus.sat, bus.Les, e.hexs, e.sat, e.les);
      end
    end
  endtask

  task automatic test_scan;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.Scan !== 2'b00) begin
      n_fail++;
      $display("FAIL scan_reset: Scan=%b want 00", bus.Scan);
    end
    rst = 1'b0;
    m_sc = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.Scan !== 2'((k % 16) / 4)) begin
        n_fail++;
        $display("FAIL scan[%0d]: Scan=%b want %b", k, bus.Scan, 2'((k % 16) / 4));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.clr     = 1'b0;
    bus.hit     = 1'b0;
    bus.hit_pts = 4'd0;
    #12;
    test_reset;
    test_back_to_back;
    test_ripple_carry;
    test_saturation;
    test_sat_display;
    test_clr_priority;
    test_scan;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
